// File: rtl/reorder_buffer_mc_if.sv
// rtl/reorder_buffer_mc_if.sv - alloc/completion/commit bundle for reorder_buffer_mc
interface reorder_buffer_mc_if #(
    parameter int ROB_ENTRIES  = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int CMPL_PORTS   = 2,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int CAUSE_W      = 4
) ();
    localparam int IDX_W = $clog2(ROB_ENTRIES);
    localparam int CNT_W = $clog2(ROB_ENTRIES + 1);

    logic                           alloc_valid_i;
    logic                           alloc_ready_o;
    logic                           alloc_is_wb_i;
    logic [REG_W-1:0]               alloc_reg_id_i;
    logic [DATA_W-1:0]              alloc_pc_i;
    logic                           alloc_excp_i;
    logic [CAUSE_W-1:0]             alloc_excp_cause_i;
    logic [IDX_W-1:0]               alloc_idx_o;

    logic [CMPL_PORTS-1:0]          cmpl_valid_i;
    logic [CMPL_PORTS*IDX_W-1:0]    cmpl_idx_i;
    logic [CMPL_PORTS*DATA_W-1:0]   cmpl_data_i;
    logic [CMPL_PORTS-1:0]          cmpl_excp_i;
    logic [CMPL_PORTS*CAUSE_W-1:0]  cmpl_excp_cause_i;

    logic [COMMIT_WIDTH-1:0]        commit_valid_o;
    logic [COMMIT_WIDTH-1:0]        commit_is_wb_o;
    logic [COMMIT_WIDTH*REG_W-1:0]  commit_reg_id_o;
    logic [COMMIT_WIDTH*DATA_W-1:0] commit_data_o;
    logic [COMMIT_WIDTH*DATA_W-1:0] commit_pc_o;

    logic                           excp_we_o;
    logic [CAUSE_W-1:0]             excp_cause_o;
    logic [DATA_W-1:0]              excp_pc_o;
    logic                           flush_o;
    logic [CNT_W-1:0]               count_o;
    logic                           empty_o;
    logic                           full_o;

    modport master (
        output alloc_valid_i, alloc_is_wb_i, alloc_reg_id_i, alloc_pc_i,
               alloc_excp_i, alloc_excp_cause_i,
               cmpl_valid_i, cmpl_idx_i, cmpl_data_i, cmpl_excp_i, cmpl_excp_cause_i,
        input  alloc_ready_o, alloc_idx_o,
               commit_valid_o, commit_is_wb_o, commit_reg_id_o, commit_data_o, commit_pc_o,
               excp_we_o, excp_cause_o, excp_pc_o, flush_o, count_o, empty_o, full_o
    );

    modport slave (
        input  alloc_valid_i, alloc_is_wb_i, alloc_reg_id_i, alloc_pc_i,
               alloc_excp_i, alloc_excp_cause_i,
               cmpl_valid_i, cmpl_idx_i, cmpl_data_i, cmpl_excp_i, cmpl_excp_cause_i,
        output alloc_ready_o, alloc_idx_o,
               commit_valid_o, commit_is_wb_o, commit_reg_id_o, commit_data_o, commit_pc_o,
               excp_we_o, excp_cause_o, excp_pc_o, flush_o, count_o, empty_o, full_o
    );
endinterface

// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - multi-port reorder buffer with wide in-order commit
module reorder_buffer_mc #(
    parameter int ROB_ENTRIES  = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int CMPL_PORTS   = 2,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int CAUSE_W      = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reorder_buffer_mc_if.slave bus
);
    localparam int IDX_W = $clog2(ROB_ENTRIES);
    localparam int CNT_W = $clog2(ROB_ENTRIES + 1);
    localparam logic [IDX_W:0]   DEPTH     = (IDX_W+1)'(ROB_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROB_ENTRIES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ROB_ENTRIES);

    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ROB_ENTRIES-1:0] busy_q, busy_d, done_q, done_d, excp_q, excp_d;

    logic                   is_wb_q  [ROB_ENTRIES];
    logic [REG_W-1:0]       reg_id_q [ROB_ENTRIES];
    logic [DATA_W-1:0]      pc_q     [ROB_ENTRIES];
    logic [DATA_W-1:0]      data_q   [ROB_ENTRIES];
    logic [CAUSE_W-1:0]     cause_q  [ROB_ENTRIES];

    logic                   full, empty, flush, alloc_fire, win_open;
    logic [IDX_W-1:0]       slot_idx [COMMIT_WIDTH];
    logic [IDX_W:0]         slot_sum, head_sum;
    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic [CNT_W-1:0]       ncommit;
    logic [CMPL_PORTS-1:0]  cmpl_hit;
    logic [IDX_W-1:0]       cmpl_idx [CMPL_PORTS];

    logic [COMMIT_WIDTH-1:0]        commit_is_wb;
    logic [COMMIT_WIDTH*REG_W-1:0]  commit_reg_id;
    logic [COMMIT_WIDTH*DATA_W-1:0] commit_data, commit_pc;
    logic [CAUSE_W-1:0]             excp_cause;
    logic [DATA_W-1:0]              excp_pc;

    assign full       = (count_q == DEPTH_CNT);
    assign empty      = (count_q == '0);
    // Excp flag is cleared on retire/flush, so busy&&excp at head means a live exception
    assign flush      = busy_q[head_q] && excp_q[head_q];
    assign alloc_fire = bus.alloc_valid_i && !full && !flush;

    // Decode completion ports; a port only counts if its target is currently allocated
    always_comb begin
        cmpl_hit = '0;
        cmpl_idx = '{default: '0};
        for (int p = 0; p < CMPL_PORTS; p++) begin
            cmpl_idx[p] = bus.cmpl_idx_i[p*IDX_W +: IDX_W];
            cmpl_hit[p] = bus.cmpl_valid_i[p] && ({1'b0, cmpl_idx[p]} < DEPTH)
                          && busy_q[cmpl_idx[p]];
        end
    end

    // Retire window: contiguous run of done, non-exception entries starting at head
    always_comb begin
        win_open     = 1'b1;
        commit_valid = '0;
        ncommit      = '0;
        slot_sum     = '0;
        slot_idx     = '{default: '0};
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_sum = {1'b0, head_q} + (IDX_W+1)'(k);
            if (slot_sum >= DEPTH) slot_sum = slot_sum - DEPTH;
            slot_idx[k] = slot_sum[IDX_W-1:0];
            if (win_open && (CNT_W'(k) < count_q) && done_q[slot_idx[k]]
                && !excp_q[slot_idx[k]]) begin
                commit_valid[k] = 1'b1;
                ncommit         = ncommit + CNT_W'(1);
            end else begin
                win_open = 1'b0;
            end
        end
    end

    // Next-state for pointers and per-entry flags; flush overrides everything
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        excp_d = excp_q;
        for (int p = 0; p < CMPL_PORTS; p++) begin
            if (cmpl_hit[p]) begin
                done_d[cmpl_idx[p]] = 1'b1;
                if (bus.cmpl_excp_i[p]) excp_d[cmpl_idx[p]] = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k]) begin
                busy_d[slot_idx[k]] = 1'b0;
                done_d[slot_idx[k]] = 1'b0;
                excp_d[slot_idx[k]] = 1'b0;
            end
        end
        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            excp_d[tail_q] = bus.alloc_excp_i;
        end
        head_sum = {1'b0, head_q} + (IDX_W+1)'(ncommit);
        if (head_sum >= DEPTH) head_sum = head_sum - DEPTH;
        head_d  = head_sum[IDX_W-1:0];
        tail_d  = tail_q;
        if (alloc_fire) tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + IDX_W'(1);
        count_d = count_q + CNT_W'(alloc_fire) - ncommit;
        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            excp_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            excp_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            excp_q  <= excp_d;
        end
    end

    // Payload storage; later ports overwrite earlier ones on an index collision
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            is_wb_q[tail_q]  <= bus.alloc_is_wb_i;
            reg_id_q[tail_q] <= bus.alloc_reg_id_i;
            pc_q[tail_q]     <= bus.alloc_pc_i;
            if (bus.alloc_excp_i) cause_q[tail_q] <= bus.alloc_excp_cause_i;
        end
        for (int p = 0; p < CMPL_PORTS; p++) begin
            if (cmpl_hit[p]) begin
                data_q[cmpl_idx[p]] <= bus.cmpl_data_i[p*DATA_W +: DATA_W];
                if (bus.cmpl_excp_i[p])
                    cause_q[cmpl_idx[p]] <= bus.cmpl_excp_cause_i[p*CAUSE_W +: CAUSE_W];
            end
        end
    end

    // Commit and exception payload, zeroed when the slot is not retiring
    always_comb begin
        commit_is_wb  = '0;
        commit_reg_id = '0;
        commit_data   = '0;
        commit_pc     = '0;
        excp_cause    = '0;
        excp_pc       = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k]) begin
                commit_is_wb[k]                  = is_wb_q[slot_idx[k]];
                commit_reg_id[k*REG_W +: REG_W]  = reg_id_q[slot_idx[k]];
                commit_data[k*DATA_W +: DATA_W]  = data_q[slot_idx[k]];
                commit_pc[k*DATA_W +: DATA_W]    = pc_q[slot_idx[k]];
            end
        end
        if (flush) begin
            excp_cause = cause_q[head_q];
            excp_pc    = pc_q[head_q];
        end
    end

    assign bus.alloc_ready_o   = !full;
    assign bus.alloc_idx_o     = tail_q;
    assign bus.commit_valid_o  = commit_valid;
    assign bus.commit_is_wb_o  = commit_is_wb;
    assign bus.commit_reg_id_o = commit_reg_id;
    assign bus.commit_data_o   = commit_data;
    assign bus.commit_pc_o     = commit_pc;
    assign bus.excp_we_o       = flush;
    assign bus.excp_cause_o    = excp_cause;
    assign bus.excp_pc_o       = excp_pc;
    assign bus.flush_o         = flush;
    assign bus.count_o         = count_q;
    assign bus.empty_o         = empty;
    assign bus.full_o          = full;
endmodule
